// File: rtl/shake_arb_pkg.sv
// Shared types and constants for the SHAKE core arbiter
// and the sampler clients that use it.
package shake_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        OWNED,
        RELEASE
    } arb_state_t;

    localparam logic SHAKE128 = 1'b0;
    localparam logic SHAKE256 = 1'b1;

    localparam int RATE128 = 1344;
    localparam int RATE256 = 1088;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selection: first set request at or after ptr,
// wrapping around. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);
    import shake_arb_pkg::*;

    int k;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE sponge among NREQ clients: round-robin grant,
// one-cycle sponge clear, then handshake pass-through until release.
module shake_arbiter
    import shake_arb_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64,
    parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1,
    parameter int ID_W          = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_mode,
    output logic [NREQ-1:0]              gnt,
    input  logic [NREQ*DATA_IN_BITS-1:0] c_data_in,
    input  logic [NREQ-1:0]              c_in_valid,
    input  logic [NREQ-1:0]              c_in_last,
    input  logic [NREQ-1:0]              c_out_ready,
    input  logic [NREQ*LEN_W-1:0]        c_last_len,
    output logic [NREQ-1:0]              c_in_ready,
    output logic [NREQ-1:0]              c_out_valid,
    output logic [DATA_OUT_BITS-1:0]     c_data_out,
    output logic [DATA_IN_BITS-1:0]      shake_data_in,
    output logic                         in_valid,
    output logic                         in_last,
    output logic                         out_ready,
    output logic [LEN_W-1:0]             last_len,
    output logic                         shake_clear,
    output logic                         shake_mode,
    input  logic [DATA_OUT_BITS-1:0]     shake_data_out,
    input  logic                         out_valid,
    input  logic                         in_ready,
    output logic                         busy,
    output logic [ID_W-1:0]              owner,
    output logic                         err_abort
);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick_idx;
    logic            pick_valid;
    logic            owned;
    logic            absorb_open;
    logic            absorb_open_nx;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owned = (state == OWNED);
    assign busy  = (state != IDLE);

    // Everything below muxes on the registered owner only.
    always_comb begin
        in_valid      = owned & c_in_valid[owner];
        in_last       = owned & c_in_last[owner];
        out_ready     = owned & c_out_ready[owner];
        shake_data_in = '0;
        last_len      = '0;
        c_data_out    = '0;
        if (owned) begin
            shake_data_in = c_data_in[int'(owner)*DATA_IN_BITS +: DATA_IN_BITS];
            last_len      = c_last_len[int'(owner)*LEN_W +: LEN_W];
            c_data_out    = shake_data_out;
        end
        c_in_ready         = '0;
        c_out_valid        = '0;
        c_in_ready[owner]  = owned & in_ready;
        c_out_valid[owner] = owned & out_valid;
    end

    always_comb begin
        absorb_open_nx = absorb_open;
        if (in_valid && in_ready) absorb_open_nx = !in_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            shake_mode  <= SHAKE128;
            shake_clear <= 1'b0;
            err_abort   <= 1'b0;
            absorb_open <= 1'b0;
        end else begin
            shake_clear <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        gnt         <= NREQ'(1) << pick_idx;
                        shake_mode  <= req_mode[pick_idx];
                        shake_clear <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    absorb_open <= 1'b0;
                    state       <= OWNED;
                end
                OWNED: begin
                    absorb_open <= absorb_open_nx;
                    if (!req[owner]) begin
                        gnt   <= '0;
                        state <= RELEASE;
                        // A message cut short mid-absorb is flagged.
                        if (absorb_open_nx) err_abort <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (int'(owner) == NREQ - 1) rr_ptr <= '0;
                    else rr_ptr <= owner + ID_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Arbiter and sequencer that shares one SHAKE128/256 sponge core among `NREQ` sampling clients, such as the challenge sampler and the matrix/vector expanders. It selects one client round-robin and issues a one-cycle sponge clear with the client's mode. It then passes that client's absorb/squeeze handshakes straight through until the client releases the core. It sits between the sampler FSMs and the single Keccak instance in the signing/keygen datapath.

## Interface
Parameters:
- `NREQ`, 4, number of requesters
- `DATA_IN_BITS`, 64, absorb word width
- `DATA_OUT_BITS`, 64, squeeze word width
- `LEN_W`, `$clog2(DATA_IN_BITS)+1`, width of `last_len`
- `ID_W`, `$clog2(NREQ)`, owner index width

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `req`  in  NREQ  client holds high for the whole message (absorb plus all squeezes)
- `req_mode`  in  NREQ  per client: 1 = SHAKE256, 0 = SHAKE128; sampled at grant
- `gnt`  out  NREQ  one-hot, registered owner
- `c_data_in`  in  NREQ*DATA_IN_BITS  client absorb data, slice i belongs to client i
- `c_in_valid`, `c_in_last`, `c_out_ready`  in  NREQ each  client handshake
- `c_last_len`  in  NREQ*LEN_W  client final-word bit count
- `c_in_ready`, `c_out_valid`  out  NREQ each  gated core handshake back to the client
- `c_data_out`  out  DATA_OUT_BITS  squeeze data broadcast to all clients
- `shake_data_in`  out  DATA_IN_BITS  to core
- `in_valid`, `in_last`, `out_ready`  out  1  to core
- `last_len`  out  LEN_W  to core
- `shake_clear`  out  1  one-cycle sponge re-init pulse
- `shake_mode`  out  1  to core
- `shake_data_out`  in  DATA_OUT_BITS  from core
- `out_valid`, `in_ready`  in  1  from core
- `busy`  out  1  state != IDLE
- `owner`  out  ID_W  index of the current or last owner
- `err_abort`  out  1  sticky; set when a client releases mid-absorb

## Operation
- States: IDLE, CLEAR, OWNED, RELEASE.
- **IDLE**
  - If `req != 0`, pick the first set bit at or after `rr_ptr`, wrapping around.
  - Register `owner`, `gnt`, and `shake_mode <= req_mode[owner]`, then go to CLEAR.
- **CLEAR**
  - `shake_clear = 1` for exactly this cycle. All core handshakes are forced to 0.
  - Next state is OWNED unconditionally.
- **OWNED** (pass-through, using the registered `owner`)
  - `in_valid = c_in_valid[owner]`; `in_last`, `last_len` and `shake_data_in` come from the owner's slice.
  - `out_ready = c_out_ready[owner]`.
  - `c_in_ready[owner] = in_ready` and `c_out_valid[owner] = out_valid`. For all other clients these are 0.
  - A beat transfers when valid && ready on the core side, per the core's protocol.
  - When `req[owner] == 0`, go to RELEASE.
- **RELEASE**
  - Force `in_valid = out_ready = 0` and clear `gnt`.
  - Set `rr_ptr <= owner+1` (mod NREQ), then go to IDLE.
- Abort detection:
  - An absorb-open flag is set on an accepted non-last absorb beat and cleared on an accepted `in_last` beat or on CLEAR.
  - A release while the flag is set makes `err_abort` go high.
  - The next CLEAR re-initialises the sponge regardless.
- `req` of non-owners is ignored until IDLE. A requester that drops `req` before being granted loses its turn without error.

## Timing
- Reset values:
  - `gnt = 0`, `owner = 0`, `rr_ptr = 0`, `shake_mode = 0`, `err_abort = 0`
  - `shake_clear = 0`, `in_valid = 0`, `in_last = 0`, `out_ready = 0`, `busy = 0`
  - All `c_*` outputs are 0; `state = IDLE`.
- Grant latency: `req` rising at edge t (while IDLE) gives `gnt` and `shake_clear` at t+1, OWNED at t+2. The earliest data beat is at t+2.
- Release latency: `req[owner]` low sampled at t gives RELEASE at t+1 and IDLE at t+2. A waiting requester is granted at t+3.
- Pass-through adds no added latency. There is no combinational path from `req` to `gnt`; handshake paths are combinational only through the registered `owner`.
- Simultaneous events:
  - If release and another `req` occur in the same cycle, the new `req` waits for IDLE.
  - If all requests are asserted, the grant order from reset is 0, 1, 2, 3, 0, ….
- Reset mid-operation: the next edge returns to IDLE and forces all core handshakes low. The core is reset by the same `rst_n`.

## Structure
- `shake_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE/CLEAR/OWNED/RELEASE);
  - the `SHAKE128`/`SHAKE256` mode constants;
  - the `RATE128 = 1344` and `RATE256 = 1088` constants, shared with the samplers.
- One sub-module, `rr_pick`: combinational round-robin selection over `req` and `rr_ptr`. It outputs `valid` plus an index.

## Test plan
- Single client 2 (mode 1) absorbs 8 words (last beat has `last_len = 64`), squeezes 17 words, drops `req` → `shake_clear` pulses once at t+1, `shake_mode = 1`, all 25 beats pass bit-exact, client 2 returns to IDLE 2 cycles after drop.
- `req = 4'b1111` held high; each client releases after 3 squeezes → grants in order 0, 1, 2, 3, 0; exactly one CLEAR per grant; non-owners see `c_in_ready = c_out_valid = 0` throughout.
- Owner stalls by toggling `c_out_ready` while core `out_valid` is held → beats are accepted only on ready-high cycles, with no duplicate or lost words.
- Client 1 drops `req` after 3 of 8 absorb words → `err_abort = 1` and stays set; the next grant still issues `shake_clear`.
- `rst_n = 0` for one cycle while OWNED mid-squeeze → the next cycle shows `gnt = 0`, `in_valid = out_ready = 0`, `busy = 0`, `rr_ptr = 0`.
- Client 3 releases while client 0 asserts `req` in the same cycle → client 0 is granted at t+3 (`rr_ptr` wraps from 3 to 0).
